// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array feeder slice.
package systolic_pkg;

   localparam int unsigned N_DEF       = 4;
   localparam int unsigned W_DEF       = 4;
   localparam int unsigned MAC_LAT_DEF = 1;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      STREAM,
      FLUSH,
      DONE
   } feeder_state_t;

   // The last operand reaches PE(N-1,N-1) after both skews, then needs MAC_LAT to land.
   function automatic int unsigned flush_cycles(input int unsigned n, input int unsigned mac_lat);
      return 2 * (n - 1) + mac_lat;
   endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth operand delay for one array edge lane; DEPTH=0 is a pass-through.
module skew_delay_line
   import systolic_pkg::*;
#(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned W     = W_DEF
) (
   input  logic         clk,
   input  logic         res,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_ctrl;
         assign unused_ctrl = clk ^ res;
         assign q = d;
      end else begin : g_shift
         logic [W-1:0] sr [DEPTH];

         always_ff @(posedge clk) begin
            if (!res) begin
               for (int unsigned k = 0; k < DEPTH; k++) sr[k] <= '0;
            end else begin
               sr[0] <= d;
               for (int unsigned k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
            end
         end

         assign q = sr[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/systolic_skew_feeder.sv
// Diagonal operand skew and clear/flush sequencing for the NxN MAC array.
// Optional FEEDER_BEAT_COUNT_EN adds beat_cnt and a sticky err_overflow.
module systolic_skew_feeder
   import systolic_pkg::*;
#(
   parameter int unsigned N       = N_DEF,
   parameter int unsigned W       = W_DEF,
   parameter int unsigned MAC_LAT = MAC_LAT_DEF
) (
   input  logic           clk,
   input  logic           res,
   input  logic           start,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N*W-1:0] in_a,
   input  logic [N*W-1:0] in_b,
   input  logic           in_last,
   output logic [N*W-1:0] out_a,
   output logic [N*W-1:0] out_b,
   output logic           mac_clr,
   output logic           busy,
   output logic           done
`ifdef FEEDER_BEAT_COUNT_EN
   ,
   output logic [7:0]     beat_cnt,
   output logic           err_overflow
`endif
);

   localparam int unsigned FLUSH_CYC = flush_cycles(N, MAC_LAT);
   localparam int unsigned CW        = $clog2(FLUSH_CYC + 1);

   feeder_state_t  state;
   logic [CW-1:0]  flush_cnt;
   logic           accept;
   logic [N*W-1:0] stage_a;
   logic [N*W-1:0] stage_b;

   // in_ready is a registered copy of (state == STREAM), so this is the handshake.
   assign accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!res) begin
         state     <= IDLE;
         flush_cnt <= '0;
         in_ready  <= 1'b0;
         mac_clr   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         mac_clr <= 1'b0;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= CLEAR;
                  mac_clr <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            CLEAR: begin
               state    <= STREAM;
               in_ready <= 1'b1;
            end
            STREAM: begin
               if (accept && in_last) begin
                  state     <= FLUSH;
                  in_ready  <= 1'b0;
                  flush_cnt <= CW'(FLUSH_CYC);
               end
            end
            FLUSH: begin
               if (flush_cnt <= CW'(1)) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  flush_cnt <= flush_cnt - 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

   // Stage 0 is shared by every lane; non-accept cycles inject zeros (0*0 is harmless to the sums).
   always_ff @(posedge clk) begin
      if (!res) begin
         stage_a <= '0;
         stage_b <= '0;
      end else begin
         stage_a <= accept ? in_a : '0;
         stage_b <= accept ? in_b : '0;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      skew_delay_line #(.DEPTH(i), .W(W)) u_skew_a (
         .clk (clk),
         .res (res),
         .d   (stage_a[i*W +: W]),
         .q   (out_a[i*W +: W])
      );
      skew_delay_line #(.DEPTH(i), .W(W)) u_skew_b (
         .clk (clk),
         .res (res),
         .d   (stage_b[i*W +: W]),
         .q   (out_b[i*W +: W])
      );
   end

`ifdef FEEDER_BEAT_COUNT_EN
   always_ff @(posedge clk) begin
      if (!res) begin
         beat_cnt     <= '0;
         err_overflow <= 1'b0;
      end else if (state == IDLE && start) begin
         beat_cnt     <= '0;
         err_overflow <= 1'b0;
      end else if (accept) begin
         if (beat_cnt == 8'hFF) err_overflow <= 1'b1;
         else                   beat_cnt     <= beat_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder with a behavioural 4x4 MAC array on its outputs.
module tb_systolic_skew_feeder;
   localparam int N = 4;
   localparam int W = 4;

   logic           clk = 1'b0;
   logic           res;
   logic           start;
   logic           in_valid;
   logic           in_ready;
   logic [N*W-1:0] in_a;
   logic [N*W-1:0] in_b;
   logic           in_last;
   logic [N*W-1:0] out_a;
   logic [N*W-1:0] out_b;
   logic           mac_clr;
   logic           busy;
   logic           done;
`ifdef FEEDER_BEAT_COUNT_EN
   logic [7:0]     beat_cnt;
   logic           err_overflow;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   systolic_skew_feeder #(.N(N), .W(W), .MAC_LAT(1)) dut (
      .clk      (clk),
      .res      (res),
      .start    (start),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_last  (in_last),
      .out_a    (out_a),
      .out_b    (out_b),
      .mac_clr  (mac_clr),
      .busy     (busy),
      .done     (done)
`ifdef FEEDER_BEAT_COUNT_EN
      ,
      .beat_cnt     (beat_cnt),
      .err_overflow (err_overflow)
`endif
   );

   // Behavioural output-stationary array: a flows east, b flows south, one register per PE.
   int pa [N][N];
   int pb [N][N];
   int ps [N][N];

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            int ain, bin;
            ain = (j == 0) ? int'(out_a[i*W +: W]) : pa[i][j-1];
            bin = (i == 0) ? int'(out_b[j*W +: W]) : pb[i-1][j];
            if (!res || mac_clr) begin
               pa[i][j] <= 0;
               pb[i][j] <= 0;
               ps[i][j] <= 0;
            end else begin
               pa[i][j] <= ain;
               pb[i][j] <= bin;
               ps[i][j] <= ps[i][j] + ain * bin;
            end
         end
      end
   end

   // Per-cycle log: outputs of the cycle, plus whether a slice is accepted at its closing edge.
   bit             logging = 1'b0;
   logic [N*W-1:0] log_a [$];
   logic [N*W-1:0] log_b [$];
   bit             log_acc [$];
   bit             log_clr [$];

   always begin
      @(negedge clk);
      #2;
      if (logging) begin
         log_a.push_back(out_a);
         log_b.push_back(out_b);
         log_acc.push_back(in_valid && in_ready);
         log_clr.push_back(mac_clr);
      end
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic int lane(input logic [N*W-1:0] v, input int i);
      return int'(v[i*W +: W]);
   endfunction

   function automatic int first_acc();
      for (int k = 0; k < log_acc.size(); k++) if (log_acc[k]) return k;
      return -1;
   endfunction

   task automatic clear_log();
      log_a.delete();
      log_b.delete();
      log_acc.delete();
      log_clr.delete();
   endtask

   // Slice k carries a = k+abase and b = k+bbase on every lane.
   task automatic do_product(input int nb, input bit bub, input int abase, input int bbase,
                             input int exp_sum);
      int waited;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("clear_pulse", mac_clr, 1);
      check("clear_ready", in_ready, 0);
      check("clear_busy", busy, 1);
      tick();
      check("clear_drop", mac_clr, 0);
      for (int k = 0; k < nb; k++) begin
         if (bub && k > 0) begin
            in_valid = 1'b0;
            in_a     = '0;
            in_b     = '0;
            in_last  = 1'b0;
            check("bubble_ready", in_ready, 1);
            tick();
         end
         in_valid = 1'b1;
         in_a     = {N{W'(k + abase)}};
         in_b     = {N{W'(k + bbase)}};
         in_last  = (k == nb - 1);
         check("stream_ready", in_ready, 1);
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_a     = '0;
      in_b     = '0;
      check("flush_ready", in_ready, 0);
      waited = 1;
      while (!done && waited < 40) begin
         tick();
         waited++;
      end
      check("done_latency", waited, 8);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            check($sformatf("sum_%0d%0d", i, j), ps[i][j], exp_sum);
      tick();
      check("done_width", done, 0);
      check("idle_busy", busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int p;
      bit saw_done;

      // reset held with start and in_valid asserted
      res      = 1'b0;
      start    = 1'b1;
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_a     = '1;
      in_b     = '1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("rst_ready", in_ready, 0);
         check("rst_busy", busy, 0);
         check("rst_done", done, 0);
         check("rst_clr", mac_clr, 0);
         check("rst_out_a", out_a, 0);
         check("rst_out_b", out_b, 0);
      end
      res      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_a     = '0;
      in_b     = '0;
      tick();
      check("idle_busy0", busy, 0);

      // single 1x1 slice: a=2, b=3
      clear_log();
      logging = 1'b1;
      do_product(1, 1'b0, 2, 3, 6);
      logging = 1'b0;
      p = first_acc();
      check("acc_found", (p >= 1) ? 1 : 0, 1);
      if (p >= 1) begin
         check("clr_before_acc", log_clr[p-1], 1);
         check("clr_at_acc", log_clr[p], 0);
         check("pre_out_a", log_a[p], 0);
         for (int i = 0; i < N; i++) begin
            check($sformatf("one_a_%0d", i), log_a[p+1+i], longint'(2) << (i * W));
            check($sformatf("one_b_%0d", i), log_b[p+1+i], longint'(3) << (i * W));
         end
         check("post_out_a", log_a[p+1+N], 0);
      end

      // four consecutive slices 1..4: sum 1+4+9+16 = 30
      clear_log();
      logging = 1'b1;
      do_product(4, 1'b0, 1, 1, 30);
      logging = 1'b0;
      p = first_acc();
      check("acc4_found", (p >= 0) ? 1 : 0, 1);
      if (p >= 0) begin
         for (int k = 0; k < 4; k++) begin
            check($sformatf("skew_l0_%0d", k), lane(log_a[p+1+k], 0), k + 1);
            check($sformatf("skew_l3_%0d", k), lane(log_a[p+4+k], 3), k + 1);
            check($sformatf("skew_b3_%0d", k), lane(log_b[p+4+k], 3), k + 1);
         end
      end

      // bubbles between every slice: same sums, zeros interleaved
      clear_log();
      logging = 1'b1;
      do_product(4, 1'b1, 1, 1, 30);
      logging = 1'b0;
      p = first_acc();
      check("accb_found", (p >= 0) ? 1 : 0, 1);
      if (p >= 0) begin
         check("bub_l0_a", lane(log_a[p+1], 0), 1);
         check("bub_l0_b", lane(log_a[p+2], 0), 0);
         check("bub_l0_c", lane(log_a[p+3], 0), 2);
         check("bub_l0_d", lane(log_a[p+4], 0), 0);
         check("bub_l3_a", lane(log_a[p+4], 3), 1);
         check("bub_l3_b", lane(log_a[p+5], 3), 0);
      end

      // reset in the middle of FLUSH
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_a     = {N{W'(5)}};
      in_b     = {N{W'(5)}};
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_a     = '0;
      in_b     = '0;
      check("mid_flush_busy", busy, 1);
      tick();
      tick();
      res = 1'b0;
      tick();
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", in_ready, 0);
      check("mid_rst_out_a", out_a, 0);
      check("mid_rst_out_b", out_b, 0);
      check("mid_rst_done", done, 0);
      res = 1'b1;
      saw_done = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (done) saw_done = 1'b1;
      end
      check("mid_rst_no_done", saw_done, 0);
      do_product(4, 1'b0, 1, 1, 30);

`ifdef FEEDER_BEAT_COUNT_EN
      // 256 beats: values wrap 1..15,0 sixteen times, so sums are 16*1240
      do_product(256, 1'b0, 1, 1, 19840);
      check("cnt_sat", beat_cnt, 255);
      check("cnt_ovf", err_overflow, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("cnt_clear", beat_cnt, 0);
      check("ovf_clear", err_overflow, 0);
      res = 1'b0;
      tick();
      res = 1'b1;
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
